dec3to8_seq: RTL and testbench

Registered, handshaked 3-to-8 one-hot decoder: the decode-side counterpart of the team's 8-to-3 encoder. Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line on `y` for a programmable number of cycles. A scan mode automatically walks codes 0..7 so the encoder can be exercised from a live source. Sits between a control source (CPU register or test sequencer) and any block expecting one-hot select or strobe lines.

---
 rtl/dec3to8_seq_if.sv | 9 +
 rtl/dec3to8_seq.sv | 148 ++++++++++++++
 tb/tb_dec3to8_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dec3to8_seq_if.sv
// rtl/dec3to8_seq_if.sv - code handshake channel for the 3-to-8 decoder
interface dec3to8_seq_if;
  logic [2:0] a;
  logic       a_valid;
  logic       a_ready;

  modport master (output a, output a_valid, input a_ready);
  modport slave  (input a, input a_valid, output a_ready);
endinterface

// File: rtl/dec3to8_seq.sv
// rtl/dec3to8_seq.sv - registered handshaked 3-to-8 one-hot decoder with scan sweep
module dec3to8_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               scan,
  dec3to8_seq_if.slave       code_if,
  output logic [7:0]         y,
  output logic               busy,
  output logic               done,
  output logic               last
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;
  logic       scanning_q, scanning_d;
  logic [7:0] y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       last_q, last_d;

  // Accepting only happens in IDLE, so ready is purely a function of state and enable.
  assign code_if.a_ready = (state_q == S_IDLE) && en;

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;
  assign last = last_q;

  // Next-state and next-output computation; done/last are single-cycle pulses by default.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    scanning_d = scanning_q;
    y_d        = y_q;
    done_d     = 1'b0;
    last_d     = 1'b0;

    if (!en) begin
      // Abort: drop everything without reporting completion.
      state_d    = S_IDLE;
      y_d        = 8'h00;
      scanning_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (scan) begin
            // Scan takes priority; a concurrent code is dropped.
            code_d     = 3'd0;
            scanning_d = 1'b1;
            y_d        = 8'h01;
            cnt_d      = HOLD_M1;
            state_d    = S_HOLD;
          end else if (code_if.a_valid) begin
            code_d     = code_if.a;
            scanning_d = 1'b0;
            y_d        = 8'd1 << code_if.a;
            cnt_d      = HOLD_M1;
            state_d    = S_HOLD;
          end
        end

        S_HOLD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            y_d    = 8'h00;
            done_d = 1'b1;
            if (scanning_q && (code_q == 3'd7)) begin
              last_d     = 1'b1;
              scanning_d = 1'b0;
              state_d    = S_IDLE;
            end else if (scanning_q) begin
              code_d = code_q + 3'd1;
              if (GAP != 0) begin
                cnt_d   = GAP_M1;
                state_d = S_GAP;
              end else begin
                // Back-to-back codes: the next line replaces the old one directly.
                y_d   = 8'd1 << (code_q + 3'd1);
                cnt_d = HOLD_M1;
              end
            end else begin
              state_d = S_IDLE;
            end
          end
        end

        S_GAP: begin
          y_d = 8'h00;
          if (cnt_q == 8'd0) begin
            y_d     = 8'd1 << code_q;
            cnt_d   = HOLD_M1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end

        default: begin
          state_d    = S_IDLE;
          y_d        = 8'h00;
          scanning_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears y without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      code_q     <= 3'd0;
      cnt_q      <= 8'd0;
      scanning_q <= 1'b0;
      y_q        <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      scanning_q <= scanning_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_dec3to8_seq.sv
// tb/tb_dec3to8_seq.sv - directed self-checking bench for dec3to8_seq
module tb_dec3to8_seq;

  logic clk;
  logic rst_n;
  logic en;
  logic scan_a, scan_b, scan_c;
  logic [7:0] y_a, y_b, y_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic last_a, last_b, last_c;

  int n_cmp;
  int n_err;
  int n_done;

  dec3to8_seq_if if_a ();
  dec3to8_seq_if if_b ();
  dec3to8_seq_if if_c ();

  dec3to8_seq #(.HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan_a), .code_if(if_a.slave),
    .y(y_a), .busy(busy_a), .done(done_a), .last(last_a)
  );

  dec3to8_seq #(.HOLD(2), .GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan_b), .code_if(if_b.slave),
    .y(y_b), .busy(busy_b), .done(done_b), .last(last_b)
  );

  dec3to8_seq #(.HOLD(2), .GAP(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan_c), .code_if(if_c.slave),
    .y(y_c), .busy(busy_c), .done(done_c), .last(last_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc8to3(input logic [7:0] v);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    n_done = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    scan_a = 1'b0; scan_b = 1'b0; scan_c = 1'b0;
    if_a.a = 3'd0; if_a.a_valid = 1'b0;
    if_b.a = 3'd0; if_b.a_valid = 1'b0;
    if_c.a = 3'd0; if_c.a_valid = 1'b0;

    // Reset state
    #3;
    chk("rst_y", {24'd0, y_a}, 32'h00);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_ready", {31'd0, if_a.a_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_y", {24'd0, y_a}, 32'h00);
    chk("idle_busy", {31'd0, busy_a}, 32'd0);
    chk("idle_ready", {31'd0, if_a.a_ready}, 32'd1);

    // Single decode of code 5 with HOLD=4
    if_a.a = 3'd5;
    if_a.a_valid = 1'b1;
    step();
    if_a.a_valid = 1'b0;
    chk("single_y0", {24'd0, y_a}, 32'h20);
    chk("single_ready_low", {31'd0, if_a.a_ready}, 32'd0);
    chk("single_busy", {31'd0, busy_a}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("single_y_hold", {24'd0, y_a}, 32'h20);
      chk("single_done_low", {31'd0, done_a}, 32'd0);
    end
    step();
    chk("single_y_clear", {24'd0, y_a}, 32'h00);
    chk("single_done", {31'd0, done_a}, 32'd1);
    chk("single_ready_done", {31'd0, if_a.a_ready}, 32'd1);
    chk("single_busy_fall", {31'd0, busy_a}, 32'd0);
    step();
    chk("single_done_pulse", {31'd0, done_a}, 32'd0);

    // All codes back-to-back with a_valid held
    if_a.a = 3'd0;
    if_a.a_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if_a.a = 3'(c + 1);
      chk("all_y_first", {24'd0, y_a}, 32'd1 << c);
      chk("all_encode", enc8to3(y_a), c);
      for (int i = 1; i < 4; i++) begin
        step();
        chk("all_y_hold", {24'd0, y_a}, 32'd1 << c);
      end
      step();
      chk("all_y_zero", {24'd0, y_a}, 32'h00);
      chk("all_done", {31'd0, done_a}, 32'd1);
      chk("all_ready", {31'd0, if_a.a_ready}, 32'd1);
      if (c == 7) if_a.a_valid = 1'b0;
    end
    step();
    chk("all_idle_y", {24'd0, y_a}, 32'h00);
    chk("all_idle_busy", {31'd0, busy_a}, 32'd0);

    // Scan with HOLD=2, GAP=1: 23 busy cycles
    scan_b = 1'b1;
    step();
    scan_b = 1'b0;
    n_done = 0;
    for (int i = 0; i < 23; i++) begin
      chk("scan_y", {24'd0, y_b}, ((i % 3) == 2) ? 32'h00 : (32'd1 << (i / 3)));
      chk("scan_busy", {31'd0, busy_b}, 32'd1);
      chk("scan_done", {31'd0, done_b}, ((i % 3) == 2) ? 32'd1 : 32'd0);
      chk("scan_last_low", {31'd0, last_b}, 32'd0);
      if (done_b) n_done++;
      step();
    end
    chk("scan_end_y", {24'd0, y_b}, 32'h00);
    chk("scan_end_done", {31'd0, done_b}, 32'd1);
    chk("scan_end_last", {31'd0, last_b}, 32'd1);
    chk("scan_end_busy", {31'd0, busy_b}, 32'd0);
    if (done_b) n_done++;
    chk("scan_done_count", n_done, 32'd8);
    step();
    chk("scan_last_pulse", {31'd0, last_b}, 32'd0);

    // Scan with GAP=0: no zero cycles between codes
    scan_c = 1'b1;
    step();
    scan_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("scan0_y", {24'd0, y_c}, 32'd1 << (i / 2));
      chk("scan0_done", {31'd0, done_c}, (((i % 2) == 0) && (i > 0)) ? 32'd1 : 32'd0);
      chk("scan0_last_low", {31'd0, last_c}, 32'd0);
      step();
    end
    chk("scan0_end_y", {24'd0, y_c}, 32'h00);
    chk("scan0_end_done", {31'd0, done_c}, 32'd1);
    chk("scan0_end_last", {31'd0, last_c}, 32'd1);
    chk("scan0_end_busy", {31'd0, busy_c}, 32'd0);
    step();

    // Abort during code 3 of a scan
    scan_b = 1'b1;
    step();
    scan_b = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abort_pre_y", {24'd0, y_b}, 32'h08);
    en = 1'b0;
    step();
    chk("abort_y", {24'd0, y_b}, 32'h00);
    chk("abort_done", {31'd0, done_b}, 32'd0);
    chk("abort_last", {31'd0, last_b}, 32'd0);
    chk("abort_busy", {31'd0, busy_b}, 32'd0);
    chk("abort_ready_en_low", {31'd0, if_b.a_ready}, 32'd0);
    en = 1'b1;
    step();
    chk("abort_stays_idle", {24'd0, y_b}, 32'h00);
    chk("abort_ready", {31'd0, if_b.a_ready}, 32'd1);

    // Asynchronous reset mid-hold
    if_a.a = 3'd2;
    if_a.a_valid = 1'b1;
    step();
    if_a.a_valid = 1'b0;
    chk("rst_mid_pre_y", {24'd0, y_a}, 32'h04);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_y", {24'd0, y_a}, 32'h00);
    chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
